// File: rtl/acc_mem_arb_pkg.sv
// rtl/acc_mem_arb_pkg.sv - shared types and helpers for the accelerator memory arbiter
package acc_mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_BURST
    } arb_state_t;

    // Tag id is sized for the largest supported requester count (16).
    localparam int ARB_TAG_ID_W = 4;

    typedef struct packed {
        logic                    valid;
        logic [ARB_TAG_ID_W-1:0] id;
    } arb_tag_t;

    function automatic int arb_id_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/acc_rr_pick.sv
// rtl/acc_rr_pick.sv - combinational rotating-priority picker
module acc_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    id,
    output logic               any
);

    // Scan offsets from farthest to nearest so the requester closest to rr_ptr wins last.
    always_comb begin
        logic [ID_W:0] idx;
        grant = '0;
        id    = '0;
        any   = 1'b0;
        idx   = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = {1'b0, rr_ptr} + (ID_W + 1)'(off);
            if (idx >= (ID_W + 1)'(NUM_REQ)) begin
                idx = idx - (ID_W + 1)'(NUM_REQ);
            end
            if (req[idx[ID_W-1:0]]) begin
                grant                = '0;
                grant[idx[ID_W-1:0]] = 1'b1;
                id                   = idx[ID_W-1:0];
                any                  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/acc_mem_arbiter.sv
// rtl/acc_mem_arbiter.sv - round-robin burst arbiter for one accelerator packet-memory port
module acc_mem_arbiter
    import acc_mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = 128,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int ACC_ADDR_WIDTH = 12,
    parameter int NUM_REQ        = 4,
    parameter int RD_LATENCY     = 1,
    parameter int MAX_BURST      = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0]                 req_last,
    input  logic [NUM_REQ*STRB_WIDTH-1:0]      req_strb,
    input  logic [NUM_REQ*ACC_ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wr_data,
    output logic [NUM_REQ-1:0]                 resp_valid,
    output logic [DATA_WIDTH-1:0]              resp_data,
    output logic                               mem_en,
    output logic [STRB_WIDTH-1:0]              mem_wen,
    output logic [ACC_ADDR_WIDTH-1:0]          mem_addr,
    output logic [DATA_WIDTH-1:0]              mem_wr_data,
    input  logic [DATA_WIDTH-1:0]              mem_rd_data
);

    localparam int ID_W  = arb_id_w(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    arb_state_t          state, state_n;
    logic [ID_W-1:0]     rr_ptr, rr_ptr_n;
    logic [ID_W-1:0]     grant_id, grant_id_n;
    logic [CNT_W-1:0]    beat_cnt, beat_cnt_n;

    logic [NUM_REQ-1:0]  pick_grant;
    logic [ID_W-1:0]     pick_id;
    logic                pick_any;

    logic [ID_W-1:0]         sel_id;
    logic                    accept;
    logic                    sel_last;
    logic [STRB_WIDTH-1:0]   sel_strb;
    logic [ACC_ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]   sel_data;

    arb_tag_t            issue_tag;
    arb_tag_t            tag_pipe [RD_LATENCY];

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] cur);
        return (cur == ID_W'(NUM_REQ - 1)) ? '0 : cur + 1'b1;
    endfunction

    acc_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .grant  (pick_grant),
        .id     (pick_id),
        .any    (pick_any)
    );

    // During a burst the grant is pinned; otherwise the picker chooses.
    assign sel_id = (state == ARB_BURST) ? grant_id : pick_id;

    // Select the chosen requester's beat fields.
    always_comb begin
        sel_last = 1'b0;
        sel_strb = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_id == ID_W'(i)) begin
                sel_last = req_last[i];
                sel_strb = req_strb[i*STRB_WIDTH +: STRB_WIDTH];
                sel_addr = req_addr[i*ACC_ADDR_WIDTH +: ACC_ADDR_WIDTH];
                sel_data = req_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Grant FSM next-state, ready and burst bookkeeping.
    always_comb begin
        state_n    = state;
        rr_ptr_n   = rr_ptr;
        grant_id_n = grant_id;
        beat_cnt_n = beat_cnt;
        req_ready  = '0;
        accept     = 1'b0;
        case (state)
            ARB_IDLE: begin
                req_ready = pick_grant;
                accept    = pick_any;
                if (pick_any) begin
                    if (sel_last || MAX_BURST == 1) begin
                        rr_ptr_n = next_id(pick_id);
                    end else begin
                        state_n    = ARB_BURST;
                        grant_id_n = pick_id;
                        beat_cnt_n = CNT_W'(1);
                    end
                end
            end
            ARB_BURST: begin
                req_ready[grant_id] = 1'b1;
                accept              = req_valid[grant_id];
                if (accept) begin
                    // Leave on the last beat or once this beat is the MAX_BURST-th.
                    if (sel_last || beat_cnt == CNT_W'(MAX_BURST - 1)) begin
                        state_n    = ARB_IDLE;
                        rr_ptr_n   = next_id(grant_id);
                        beat_cnt_n = '0;
                    end else begin
                        beat_cnt_n = beat_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = ARB_IDLE;
            end
        endcase
    end

    // Grant state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_n;
            rr_ptr   <= rr_ptr_n;
            grant_id <= grant_id_n;
            beat_cnt <= beat_cnt_n;
        end
    end

    // Registered memory issue; address and data hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en      <= 1'b0;
            mem_wen     <= '0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
        end else begin
            mem_en  <= accept;
            mem_wen <= accept ? sel_strb : '0;
            if (accept) begin
                mem_addr    <= sel_addr;
                mem_wr_data <= sel_data;
            end
        end
    end

    // Read tags: issue_tag lines up with mem_en, the pipe delays it to mem_rd_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_tag <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            issue_tag.valid <= accept && (sel_strb == '0);
            issue_tag.id    <= ARB_TAG_ID_W'(sel_id);
            tag_pipe[0]     <= issue_tag;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // Decode the aligned tag into the one-hot response strobe.
    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid[i] = tag_pipe[RD_LATENCY-1].valid
                            && (tag_pipe[RD_LATENCY-1].id == ARB_TAG_ID_W'(i));
        end
    end

    assign resp_data = mem_rd_data;

endmodule

// File: tb/tb_acc_mem_arbiter.sv
// tb/tb_acc_mem_arbiter.sv - directed self-checking bench for acc_mem_arbiter
module tb_acc_mem_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 128;
    localparam int SW  = DW / 8;
    localparam int AW  = 12;
    localparam int RDL = 3;
    localparam int MB  = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NR-1:0]      req_valid = '0;
    logic [NR-1:0]      req_ready;
    logic [NR-1:0]      req_last = '0;
    logic [NR*SW-1:0]   req_strb = '0;
    logic [NR*AW-1:0]   req_addr = '0;
    logic [NR*DW-1:0]   req_wr_data = '0;
    logic [NR-1:0]      resp_valid;
    logic [DW-1:0]      resp_data;
    logic               mem_en;
    logic [SW-1:0]      mem_wen;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wr_data;
    logic [DW-1:0]      mem_rd_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0] mem   [1024];
    logic          wrote [1024];
    logic [DW-1:0] rd_pipe [RDL];

    int            rq_cyc  [$];
    logic [NR-1:0] rq_id   [$];
    logic [DW-1:0] rq_data [$];

    acc_mem_arbiter #(
        .DATA_WIDTH     (DW),
        .STRB_WIDTH     (SW),
        .ACC_ADDR_WIDTH (AW),
        .NUM_REQ        (NR),
        .RD_LATENCY     (RDL),
        .MAX_BURST      (MB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_last    (req_last),
        .req_strb    (req_strb),
        .req_addr    (req_addr),
        .req_wr_data (req_wr_data),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .mem_en      (mem_en),
        .mem_wen     (mem_wen),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pat(input int a);
        return {4{32'hC0DE0000 | 32'(a)}};
    endfunction

    function automatic logic [DW-1:0] rd_word(input logic [9:0] a);
        return wrote[a] ? mem[a] : pat(int'(a));
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [SW-1:0] be);
        logic [DW-1:0] m;
        m = old;
        for (int b = 0; b < SW; b++) if (be[b]) m[b*8 +: 8] = d[b*8 +: 8];
        return m;
    endfunction

    // Memory model: writes on mem_en with nonzero wen, reads return after RDL cycles.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) wrote[i] <= 1'b0;
        end else if (mem_en && mem_wen != '0) begin
            mem[mem_addr[9:0]]   <= merge(rd_word(mem_addr[9:0]), mem_wr_data, mem_wen);
            wrote[mem_addr[9:0]] <= 1'b1;
        end
        rd_pipe[0] <= (mem_en && mem_wen == '0) ? rd_word(mem_addr[9:0]) : '0;
        for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rd_data = rd_pipe[RDL-1];

    // Response log.
    always @(negedge clk) begin
        if (!rst && resp_valid != '0) begin
            rq_cyc.push_back(cyc);
            rq_id.push_back(resp_valid);
            rq_data.push_back(resp_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req_valid   = '0;
        req_last    = '0;
        req_strb    = '0;
        req_addr    = '0;
        req_wr_data = '0;
    endtask

    task automatic set_req(input int i, input logic v, input logic l, input logic [SW-1:0] s,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]              = v;
        req_last[i]               = l;
        req_strb[i*SW +: SW]      = s;
        req_addr[i*AW +: AW]      = a;
        req_wr_data[i*DW +: DW]   = d;
    endtask

    task automatic do_reset();
        clear_reqs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rq_cyc.delete();
        rq_id.delete();
        rq_data.delete();
    endtask

    task automatic test_reset();
        do_reset();
        set_req(1, 1'b1, 1'b1, '1, AW'(12'h0AB), {4{32'h5A5A1234}});
        tick();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, '0, AW'(i), '0);
        rst = 1'b1;
        @(negedge clk);
        total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL reset_mem_en: got %0h want 0", mem_en); end
        total++; if (mem_wen !== '0) begin bad++; $display("FAIL reset_mem_wen: got %0h want 0", mem_wen); end
        total++; if (mem_addr !== '0) begin bad++; $display("FAIL reset_mem_addr: got %0h want 0", mem_addr); end
        total++; if (mem_wr_data !== '0) begin bad++; $display("FAIL reset_mem_wr_data: got %0h want 0", mem_wr_data); end
        total++; if (resp_valid !== '0) begin bad++; $display("FAIL reset_resp_valid: got %0h want 0", resp_valid); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL reset_first_grant: got %b want 0001", req_ready); end
        tick();
        clear_reqs();
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready_idle: got %b want 0000", req_ready); end
        tick();
    endtask

    task automatic test_round_robin();
        int acc_cyc [5];
        logic [NR-1:0] e;
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, '0, AW'(256 + i), '0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            e = NR'(1) << (k % 4);
            total++; if (req_ready !== e) begin bad++; $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, e); end
            acc_cyc[k] = cyc;
            tick();
        end
        clear_reqs();
        repeat (RDL + 3) tick();
        total++; if (rq_cyc.size() != 5) begin bad++; $display("FAIL rr_resp_count: got %0d want 5", rq_cyc.size()); end
        for (int k = 0; k < 5 && k < rq_cyc.size(); k++) begin
            e = NR'(1) << (k % 4);
            total++; if (rq_id[k] !== e) begin bad++; $display("FAIL rr_resp_id%0d: got %b want %b", k, rq_id[k], e); end
            total++; if (rq_cyc[k] != acc_cyc[k] + 1 + RDL) begin bad++; $display("FAIL rr_resp_cyc%0d: got %0d want %0d", k, rq_cyc[k], acc_cyc[k] + 1 + RDL); end
            total++; if (rq_data[k] !== pat(256 + k % 4)) begin bad++; $display("FAIL rr_resp_data%0d: got %h want %h", k, rq_data[k], pat(256 + k % 4)); end
        end
    endtask

    task automatic test_burst_hold();
        do_reset();
        for (int b = 0; b < 5; b++) begin
            if (b >= 1) begin
                set_req(0, 1'b1, 1'b1, '0, AW'(12'h050), '0);
                set_req(1, 1'b1, 1'b1, '0, AW'(12'h051), '0);
            end
            set_req(2, 1'b1, (b == 4), '1, AW'(512 + b), DW'(32'hB000 + b));
            @(negedge clk);
            total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL hold_beat%0d: got %b want 0100", b, req_ready); end
            tick();
        end
        set_req(2, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL hold_after_wrap: got %b want 0001", req_ready); end
        total++; if (mem_addr !== AW'(516)) begin bad++; $display("FAIL hold_last_addr: got %h want 204", mem_addr); end
        total++; if (mem_wen !== 16'hFFFF) begin bad++; $display("FAIL hold_last_wen: got %h want ffff", mem_wen); end
        total++; if (mem_wr_data !== DW'(32'hB004)) begin bad++; $display("FAIL hold_last_data: got %h want b004", mem_wr_data); end
        tick();
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL hold_next: got %b want 0010", req_ready); end
        tick();
        clear_reqs();
        repeat (RDL + 3) tick();
        total++; if (rq_id.size() != 2) begin bad++; $display("FAIL hold_resp_count: got %0d want 2", rq_id.size()); end
        if (rq_id.size() == 2) begin
            total++; if (rq_id[0] !== 4'b0001 || rq_id[1] !== 4'b0010) begin bad++; $display("FAIL hold_resp_order: got %b,%b want 0001,0010", rq_id[0], rq_id[1]); end
        end
    endtask

    task automatic test_forced_release();
        logic [NR-1:0] exp_fr [11];
        int beat;
        logic served3;
        exp_fr = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                   4'b1000, 4'b0010, 4'b0010};
        beat = 0;
        served3 = 1'b0;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            set_req(1, 1'b1, (beat == 9), '1, AW'(768 + beat), DW'(beat));
            if (served3) set_req(3, 1'b0, 1'b0, '0, '0, '0);
            else         set_req(3, 1'b1, 1'b1, '0, AW'(12'h033), '0);
            @(negedge clk);
            total++; if (req_ready !== exp_fr[c]) begin bad++; $display("FAIL forced_c%0d: got %b want %b", c, req_ready, exp_fr[c]); end
            if (req_ready[1]) beat++;
            if (req_ready[3]) served3 = 1'b1;
            tick();
        end
        clear_reqs();
        total++; if (beat != 10) begin bad++; $display("FAIL forced_beats: got %0d want 10", beat); end
        repeat (RDL + 3) tick();
        total++; if (rq_id.size() != 1) begin bad++; $display("FAIL forced_resp_count: got %0d want 1", rq_id.size()); end
        if (rq_id.size() == 1) begin
            total++; if (rq_id[0] !== 4'b1000) begin bad++; $display("FAIL forced_resp_id: got %b want 1000", rq_id[0]); end
            total++; if (rq_data[0] !== pat(12'h033)) begin bad++; $display("FAIL forced_resp_data: got %h want %h", rq_data[0], pat(12'h033)); end
        end
    endtask

    task automatic test_write_read();
        logic [DW-1:0] wdata;
        int acc;
        wdata = 128'h0123456789ABCDEF_FEDCBA9876543210;
        do_reset();
        set_req(0, 1'b1, 1'b1, 16'hFFFF, AW'(12'h010), wdata);
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL wr_grant: got %b want 0001", req_ready); end
        tick();
        clear_reqs();
        set_req(2, 1'b1, 1'b1, '0, AW'(12'h010), '0);
        @(negedge clk);
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL rd_grant: got %b want 0100", req_ready); end
        total++; if (mem_en !== 1'b1) begin bad++; $display("FAIL wr_mem_en: got %0h want 1", mem_en); end
        total++; if (mem_wen !== 16'hFFFF) begin bad++; $display("FAIL wr_mem_wen: got %h want ffff", mem_wen); end
        total++; if (mem_addr !== AW'(12'h010)) begin bad++; $display("FAIL wr_mem_addr: got %h want 010", mem_addr); end
        total++; if (mem_wr_data !== wdata) begin bad++; $display("FAIL wr_mem_data: got %h want %h", mem_wr_data, wdata); end
        acc = cyc;
        tick();
        clear_reqs();
        @(negedge clk);
        total++; if (mem_en !== 1'b1 || mem_wen !== '0) begin bad++; $display("FAIL rd_issue: got en=%0h wen=%h want en=1 wen=0", mem_en, mem_wen); end
        tick();
        repeat (RDL + 2) tick();
        total++; if (rq_id.size() != 1) begin bad++; $display("FAIL wr_rd_resp_count: got %0d want 1", rq_id.size()); end
        if (rq_id.size() == 1) begin
            total++; if (rq_id[0] !== 4'b0100) begin bad++; $display("FAIL wr_rd_resp_id: got %b want 0100", rq_id[0]); end
            total++; if (rq_data[0] !== wdata) begin bad++; $display("FAIL wr_rd_resp_data: got %h want %h", rq_data[0], wdata); end
            total++; if (rq_cyc[0] != acc + 1 + RDL) begin bad++; $display("FAIL wr_rd_resp_cyc: got %0d want %0d", rq_cyc[0], acc + 1 + RDL); end
        end
    endtask

    task automatic test_reset_inflight();
        logic [NR-1:0] e;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            clear_reqs();
            set_req(r, 1'b1, 1'b1, '0, AW'(32 + r), '0);
            @(negedge clk);
            e = NR'(1) << r;
            total++; if (req_ready !== e) begin bad++; $display("FAIL inflight_rd%0d: got %b want %b", r, req_ready, e); end
            tick();
        end
        clear_reqs();
        set_req(3, 1'b1, 1'b0, '1, AW'(12'h0F0), '0);
        @(negedge clk);
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL inflight_burst: got %b want 1000", req_ready); end
        tick();
        rst = 1'b1;
        clear_reqs();
        @(negedge clk);
        total++; if (resp_valid !== '0) begin bad++; $display("FAIL inflight_rst_resp: got %b want 0000", resp_valid); end
        tick();
        rst = 1'b0;
        set_req(0, 1'b1, 1'b1, '1, AW'(12'h0F1), '0);
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL inflight_grant_released: got %b want 0001", req_ready); end
        tick();
        clear_reqs();
        repeat (RDL + 4) tick();
        total++; if (rq_id.size() != 0) begin bad++; $display("FAIL inflight_resp_after_rst: got %0d want 0", rq_id.size()); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_burst_hold();
        test_forced_release();
        test_write_read();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
